// File: rtl/alu_exec_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_stage_pkg
// Shared types and constants for the ALU execute stage:
//   ALU_WIDTH  default operand/result width
//   opcode_e   operation select encoding (101-111 reserved)
//   state_e    stage FSM states (ST_MUL only used when ALU_MUL_EN is defined)
// ---------------------------------------------------------------------------
package alu_exec_stage_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_MOV = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_MUL = 3'b100
  } opcode_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_exec_stage_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
// Iterative WIDTH x WIDTH unsigned multiplier, one shift-add step per cycle.
// The whole module only exists when ALU_MUL_EN is defined.
// Ports:
//   clk, reset_n  clock, async active-low reset (aborts a product in flight)
//   start_i       latch operands, clear accumulator, load step counter
//   a_i, b_i      multiplicand / multiplier
//   product_o     accumulator value after the current cycle's step
//   done_o        product_o is final (last step this cycle, or already done)
// ---------------------------------------------------------------------------
`ifdef ALU_MUL_EN
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               done_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      count_q;

  // Accumulator after this cycle's step; steps stop once the counter is 0.
  always_comb begin
    acc_d = acc_q;
    if ((count_q != {CW{1'b0}}) && mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end else begin
      acc_d = acc_q;
    end
  end

  // Operand shift registers, accumulator and step counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= {(2*WIDTH){1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      count_q  <= {CW{1'b0}};
    end else if (start_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      acc_q    <= {(2*WIDTH){1'b0}};
      mplier_q <= b_i;
      count_q  <= CW'(WIDTH);
    end else if (count_q != {CW{1'b0}}) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q - CW'(1);
    end
  end

  assign product_o = acc_d;
  // count 1 = final step in progress; count 0 = finished and held.
  assign done_o    = (count_q <= CW'(1));

endmodule
`endif

// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
// Registered execute stage: operand A from the register file, operand B from
// the operand-select MUX. MOV/ADD/AND/OR complete in one cycle; MUL (only
// with ALU_MUL_EN defined) iterates WIDTH cycles in a shift-add multiplier.
// Result and flags sit in a one-entry output register with valid/ready.
// Configuration macro: ALU_MUL_EN (undefined: opcode 100 is reserved).
// Ports:
//   clk, reset_n         clock, async active-low reset
//   in_valid/in_ready    upstream handshake; opcode, data1, data2 operands
//   out_valid/out_ready  downstream handshake to write-back
//   result, zero, carry, illegal  registered result and flags
//   busy                 multiply in progress
// ---------------------------------------------------------------------------
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             illegal,
  output logic             busy
);

  opcode_e          op_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic             illegal_d;

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             carry_q;
  logic             illegal_q;
  logic             out_valid_q;

  logic             free_s;
  logic             drain_s;
  logic             accept_s;
  logic             is_mul_s;

  assign op_s     = opcode_e'(opcode);
  // Output register can take a new result this edge (empty or being drained).
  assign free_s   = !out_valid_q || out_ready;
  assign drain_s  = out_valid_q && out_ready;
  assign accept_s = in_valid && in_ready;

`ifdef ALU_MUL_EN
  state_e             state_q;
  logic [2*WIDTH-1:0] mul_prod_s;
  logic               mul_done_s;
  logic               mul_start_s;
  logic               mul_load_s;

  assign is_mul_s    = (op_s == OP_MUL);
  assign mul_start_s = accept_s && is_mul_s;
  // Final product loads only when the output register is free; otherwise
  // the FSM stays in ST_MUL with the multiplier parked at count 0.
  assign mul_load_s  = (state_q == ST_MUL) && mul_done_s && free_s;
  assign in_ready    = (state_q == ST_IDLE) && free_s;
  assign busy        = (state_q == ST_MUL);

  shift_add_multiplier #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (mul_start_s),
    .a_i       (data1),
    .b_i       (data2),
    .product_o (mul_prod_s),
    .done_o    (mul_done_s)
  );
`else
  assign is_mul_s = 1'b0;
  assign in_ready = free_s;
  assign busy     = 1'b0;
`endif

  // Single-cycle datapath; anything not decoded is reserved and flags illegal.
  always_comb begin
    sum_s     = {1'b0, data1} + {1'b0, data2};
    result_d  = {WIDTH{1'b0}};
    carry_d   = 1'b0;
    illegal_d = 1'b0;
    case (op_s)
      OP_MOV: result_d = data2;
      OP_ADD: begin
        result_d = sum_s[WIDTH-1:0];
        carry_d  = sum_s[WIDTH];
      end
      OP_AND: result_d = data1 & data2;
      OP_OR:  result_d = data1 | data2;
`ifdef ALU_MUL_EN
      // Result comes from the multiplier path, not from here.
      OP_MUL: illegal_d = 1'b0;
`endif
      default: illegal_d = 1'b1;
    endcase
  end

  // Output register and FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q    <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      state_q     <= ST_IDLE;
`endif
    end else begin
      if (accept_s && !is_mul_s) begin
        result_q    <= result_d;
        zero_q      <= (result_d == {WIDTH{1'b0}});
        carry_q     <= carry_d;
        illegal_q   <= illegal_d;
        out_valid_q <= 1'b1;
`ifdef ALU_MUL_EN
      end else if (mul_load_s) begin
        result_q    <= mul_prod_s[WIDTH-1:0];
        zero_q      <= (mul_prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
        carry_q     <= |mul_prod_s[2*WIDTH-1:WIDTH];
        illegal_q   <= 1'b0;
        out_valid_q <= 1'b1;
`endif
      end else if (drain_s) begin
        out_valid_q <= 1'b0;
      end
`ifdef ALU_MUL_EN
      case (state_q)
        ST_IDLE: if (mul_start_s) state_q <= ST_MUL;
        ST_MUL:  if (mul_load_s)  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
`endif
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;

endmodule
